hyperbus_arbiter: RTL and testbench

- Two-requester arbiter and burst sequencer in front of the `hyperbus` leader controller.
- Each requester posts a fixed-length burst: address, length, direction and register-space flag.
- The block grants one requester with round-robin fairness and holds `hb_wrq`/`hb_rrq` for exactly that many words.
- It steers write data, masks, read data and strobes to the granted requester, and enforces an inter-transaction gap and a stall timeout.

---
 rtl/hyperbus_arbiter_pkg.sv | 25 ++
 rtl/hyperbus_arbiter_if.sv | 69 ++++++
 rtl/hyperbus_rr_pick.sv | 21 ++
 rtl/hyperbus_arbiter.sv | 166 ++++++++++++++++
 tb/tb_hyperbus_arbiter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hyperbus_arbiter_pkg.sv
// Shared definitions for the two-port HyperBus arbiter: FSM encodings, controller word/mask
// width relation and the default gap/timeout settings.
package hyperbus_arbiter_pkg;

  // Controller WIDTH; one arbiter word carries two controller beats.
  localparam int unsigned CtrlWidth      = 8;
  localparam int unsigned DwDefault      = 2 * CtrlWidth;
  localparam int unsigned AwDefault      = 32;
  localparam int unsigned LenWDefault    = 8;
  localparam int unsigned GapDefault     = 4;
  localparam int unsigned TimeoutDefault = 255;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StXfer = 2'd1;
  localparam state_t StDone = 2'd2;
  localparam state_t StGap  = 2'd3;

  // One mask bit per byte of a controller data word.
  function automatic int unsigned mask_w(input int unsigned dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/hyperbus_arbiter_if.sv
// Requester and controller-side signal bundle of the arbiter. The slave modport is the
// arbiter's view; the master modport is the view of whatever drives the requesters/controller.
interface hyperbus_arbiter_if #(
  parameter int unsigned DW    = hyperbus_arbiter_pkg::DwDefault,
  parameter int unsigned AW    = hyperbus_arbiter_pkg::AwDefault,
  parameter int unsigned LEN_W = hyperbus_arbiter_pkg::LenWDefault
);
  import hyperbus_arbiter_pkg::*;

  localparam int unsigned MW = mask_w(DW);

  // Requester 0
  logic             m0_req;
  logic             m0_we;
  logic [AW-1:0]    m0_adr;
  logic [LEN_W-1:0] m0_len;
  logic             m0_reg;
  logic [DW-1:0]    m0_wdat;
  logic [MW-1:0]    m0_wmask;
  logic             m0_wready;
  logic [DW-1:0]    m0_rdat;
  logic             m0_rvalid;
  logic             m0_done;
  logic             m0_err;

  // Requester 1
  logic             m1_req;
  logic             m1_we;
  logic [AW-1:0]    m1_adr;
  logic [LEN_W-1:0] m1_len;
  logic             m1_reg;
  logic [DW-1:0]    m1_wdat;
  logic [MW-1:0]    m1_wmask;
  logic             m1_wready;
  logic [DW-1:0]    m1_rdat;
  logic             m1_rvalid;
  logic             m1_done;
  logic             m1_err;

  // Controller side
  logic [AW-1:0]    hb_adr_o;
  logic [DW-1:0]    hb_dat_o;
  logic [MW-1:0]    hb_mask_o;
  logic             hb_reg_o;
  logic             hb_wrq_o;
  logic             hb_rrq_o;
  logic [DW-1:0]    hb_dat_i;
  logic             hb_ready_i;
  logic             hb_valid_i;

  modport slave (
    input  m0_req, m0_we, m0_adr, m0_len, m0_reg, m0_wdat, m0_wmask,
    output m0_wready, m0_rdat, m0_rvalid, m0_done, m0_err,
    input  m1_req, m1_we, m1_adr, m1_len, m1_reg, m1_wdat, m1_wmask,
    output m1_wready, m1_rdat, m1_rvalid, m1_done, m1_err,
    output hb_adr_o, hb_dat_o, hb_mask_o, hb_reg_o, hb_wrq_o, hb_rrq_o,
    input  hb_dat_i, hb_ready_i, hb_valid_i
  );

  modport master (
    output m0_req, m0_we, m0_adr, m0_len, m0_reg, m0_wdat, m0_wmask,
    input  m0_wready, m0_rdat, m0_rvalid, m0_done, m0_err,
    output m1_req, m1_we, m1_adr, m1_len, m1_reg, m1_wdat, m1_wmask,
    input  m1_wready, m1_rdat, m1_rvalid, m1_done, m1_err,
    input  hb_adr_o, hb_dat_o, hb_mask_o, hb_reg_o, hb_wrq_o, hb_rrq_o,
    output hb_dat_i, hb_ready_i, hb_valid_i
  );

endinterface

// File: rtl/hyperbus_rr_pick.sv
// Two-input round-robin selector: a lone requester wins, on a tie the one not granted last wins.
module hyperbus_rr_pick (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_o,
  output logic       any_o
);

  always_comb begin
    grant_o = last_grant_i;
    unique case (req_i)
      2'b01:   grant_o = 1'b0;
      2'b10:   grant_o = 1'b1;
      2'b11:   grant_o = ~last_grant_i;
      default: grant_o = last_grant_i;
    endcase
  end

  assign any_o = |req_i;

endmodule

// File: rtl/hyperbus_arbiter.sv
// Two-requester arbiter and burst sequencer in front of the HyperBus controller: round-robin
// grant, fixed-length wrq/rrq bursts, data steering, post-burst gap and stall timeout.
module hyperbus_arbiter
  import hyperbus_arbiter_pkg::*;
#(
  parameter int unsigned DW         = DwDefault,
  parameter int unsigned AW         = AwDefault,
  parameter int unsigned LEN_W      = LenWDefault,
  parameter int unsigned GAP_CYCLES = GapDefault,
  parameter int unsigned TIMEOUT    = TimeoutDefault
) (
  input logic               clk,
  input logic               rstn,
  hyperbus_arbiter_if.slave bus
);

  localparam int unsigned MW = mask_w(DW);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  // Requester fields gathered into index-by-port form
  logic [1:0]       req;
  logic [1:0]       we;
  logic [1:0]       rg;
  logic [AW-1:0]    adr   [2];
  logic [LEN_W-1:0] len   [2];
  logic [DW-1:0]    wdat  [2];
  logic [MW-1:0]    wmask [2];

  assign req      = {bus.m1_req, bus.m0_req};
  assign we       = {bus.m1_we, bus.m0_we};
  assign rg       = {bus.m1_reg, bus.m0_reg};
  assign adr[0]   = bus.m0_adr;
  assign adr[1]   = bus.m1_adr;
  assign len[0]   = bus.m0_len;
  assign len[1]   = bus.m1_len;
  assign wdat[0]  = bus.m0_wdat;
  assign wdat[1]  = bus.m1_wdat;
  assign wmask[0] = bus.m0_wmask;
  assign wmask[1] = bus.m1_wmask;

  state_t           state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_q, last_d;
  logic             err_q, err_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [GW-1:0]    gap_q, gap_d;

  logic pick;
  logic any;

  hyperbus_rr_pick u_pick (
    .req_i        (req),
    .last_grant_i (last_q),
    .grant_o      (pick),
    .any_o        (any)
  );

  logic in_xfer;
  logic wr_x;
  logic rd_x;
  logic step;
  logic last_word;
  logic fin;

  assign in_xfer   = (state_q == StXfer);
  assign wr_x      = in_xfer & we[grant_q];
  assign rd_x      = in_xfer & ~we[grant_q];
  assign step      = (wr_x & bus.hb_ready_i) | (rd_x & bus.hb_valid_i);
  assign last_word = (LEN_W'(cnt_q + 1'b1) == len[grant_q]);
  // Final word: the request has to fall in the very cycle it is accepted.
  assign fin       = step & last_word;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    gap_d   = gap_q;
    unique case (state_q)
      StIdle: begin
        if (any) begin
          grant_d = pick;
          last_d  = pick;
          cnt_d   = '0;
          tmo_d   = '0;
          if (len[pick] == '0) begin
            state_d = StDone;
            err_d   = 1'b1;
          end else begin
            state_d = StXfer;
            err_d   = 1'b0;
          end
        end
      end
      StXfer: begin
        if (step) begin
          cnt_d = LEN_W'(cnt_q + 1'b1);
          tmo_d = '0;
          if (last_word) state_d = StDone;
        end else begin
          tmo_d = TW'(tmo_q + 1'b1);
          // Stalls during the controller's latency phase count too.
          if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_d = StDone;
            err_d   = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StGap;
        gap_d   = '0;
      end
      StGap: begin
        gap_d = GW'(gap_q + 1'b1);
        if (gap_q == GW'(GAP_CYCLES - 1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
    end
  end

  logic done;
  assign done = (state_q == StDone);

  assign bus.hb_adr_o  = adr[grant_q];
  assign bus.hb_dat_o  = wdat[grant_q];
  assign bus.hb_reg_o  = rg[grant_q];
  assign bus.hb_mask_o = wr_x ? wmask[grant_q] : '1;
  assign bus.hb_wrq_o  = wr_x & ~fin;
  assign bus.hb_rrq_o  = rd_x & ~fin;

  assign bus.m0_wready = wr_x & ~grant_q & bus.hb_ready_i;
  assign bus.m1_wready = wr_x & grant_q & bus.hb_ready_i;
  assign bus.m0_rvalid = rd_x & ~grant_q & bus.hb_valid_i;
  assign bus.m1_rvalid = rd_x & grant_q & bus.hb_valid_i;
  assign bus.m0_rdat   = bus.hb_dat_i;
  assign bus.m1_rdat   = bus.hb_dat_i;
  assign bus.m0_done   = done & ~grant_q;
  assign bus.m1_done   = done & grant_q;
  assign bus.m0_err    = done & ~grant_q & err_q;
  assign bus.m1_err    = done & grant_q & err_q;

endmodule

// File: tb/tb_hyperbus_arbiter.sv
// Randomized bench for hyperbus_arbiter: plays both requesters and the controller, and checks
// grants, word handshakes, gap timing, timeout and reset against a burst-level model.
module tb_hyperbus_arbiter;

  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 32;
  localparam int unsigned LW  = 8;
  localparam int unsigned MW  = DW / 8;
  localparam int          GAP = 4;
  localparam int          TMO = 255;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  hyperbus_arbiter_if bus ();

  hyperbus_arbiter #(
    .DW         (DW),
    .AW         (AW),
    .LEN_W      (LW),
    .GAP_CYCLES (GAP),
    .TIMEOUT    (TMO)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  logic [1:0]    req, we, rg;
  logic [AW-1:0] adr   [2];
  logic [LW-1:0] len   [2];
  logic [DW-1:0] wdat  [2];
  logic [MW-1:0] wmask [2];
  logic [DW-1:0] wd    [2][8];
  logic          hb_ready, hb_valid;
  logic [DW-1:0] hb_rdat;

  assign bus.m0_req = req[0];    assign bus.m1_req = req[1];
  assign bus.m0_we = we[0];      assign bus.m1_we = we[1];
  assign bus.m0_reg = rg[0];     assign bus.m1_reg = rg[1];
  assign bus.m0_adr = adr[0];    assign bus.m1_adr = adr[1];
  assign bus.m0_len = len[0];    assign bus.m1_len = len[1];
  assign bus.m0_wdat = wdat[0];  assign bus.m1_wdat = wdat[1];
  assign bus.m0_wmask = wmask[0]; assign bus.m1_wmask = wmask[1];
  assign bus.hb_ready_i = hb_ready;
  assign bus.hb_valid_i = hb_valid;
  assign bus.hb_dat_i = hb_rdat;

  logic [1:0]    wready, rvalid, done, err;
  logic [DW-1:0] rdat [2];
  assign wready  = {bus.m1_wready, bus.m0_wready};
  assign rvalid  = {bus.m1_rvalid, bus.m0_rvalid};
  assign done    = {bus.m1_done, bus.m0_done};
  assign err     = {bus.m1_err, bus.m0_err};
  assign rdat[0] = bus.m0_rdat;
  assign rdat[1] = bus.m1_rdat;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_g = 1;
  int done_cyc = 0;
  int expect_start = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [1:0] oh(input int g, input bit v);
    if (!v) return 2'b00;
    return (g == 0) ? 2'b01 : 2'b10;
  endfunction

  // Round-robin rule: a lone requester wins; on a tie the one not served last wins.
  function automatic int pick(input logic [1:0] r, input int last);
    if (r == 2'b01) return 0;
    if (r == 2'b10) return 1;
    return (last == 0) ? 1 : 0;
  endfunction

  // A requester may only withdraw its request after seeing its done pulse.
  logic [1:0] req_prev = 2'b00;
  logic [1:0] done_prev = 2'b00;
  always @(negedge clk) begin
    if (rstn) begin
      for (int i = 0; i < 2; i++)
        if (req_prev[i] && !req[i]) check("req_hold", done_prev[i], 1);
    end
    req_prev <= req;
    done_prev <= done;
  end

  task automatic post(input int g, input bit w, input logic [AW-1:0] a, input int l, input bit r);
    we[g]    = w;
    adr[g]   = a;
    len[g]   = LW'(l);
    rg[g]    = r;
    wmask[g] = MW'($urandom);
    for (int i = 0; i < 8; i++) wd[g][i] = DW'($urandom);
    wdat[g] = wd[g][0];
    req[g]  = 1'b1;
  endtask

  // Serves the burst of requester g from grant to done; called at posedge+1.
  task automatic serve(input int g, input bit stall, input int abort_after);
    int n, stalls, waited, l;
    bit ok, started, fin;
    logic [DW-1:0] rd;
    l = int'(len[g]);
    waited = 0;
    started = 0;
    while (!started && waited < 40) begin
      @(negedge clk);
      started = bus.hb_wrq_o | bus.hb_rrq_o | (|done);
      if (!started) begin
        check("idle_mask", bus.hb_mask_o, {MW{1'b1}});
        check("idle_fwd", {wready, rvalid}, 0);
        @(posedge clk); #1;
        waited++;
        ok = (cyc < expect_start) && ($urandom_range(0, 1) == 1);
        hb_ready = ok;
        hb_valid = ok;
        hb_rdat = DW'($urandom);
      end
    end
    if (!started) begin
      check("start_timeout", 0, 1);
      return;
    end
    check("start_cyc", cyc, expect_start);
    if (l == 0) begin
      check("len0_done", done, oh(g, 1));
      check("len0_err", err, oh(g, 1));
      check("len0_rq", {bus.hb_wrq_o, bus.hb_rrq_o}, 0);
    end else begin
      check("dir", {bus.hb_wrq_o, bus.hb_rrq_o}, we[g] ? 2'b10 : 2'b01);
      check("adr", bus.hb_adr_o, adr[g]);
      check("reg", bus.hb_reg_o, rg[g]);
      check("mask", bus.hb_mask_o, we[g] ? wmask[g] : {MW{1'b1}});
      n = 0;
      stalls = 1;
      while (n < l && stalls < TMO && !(abort_after >= 0 && n == abort_after)) begin
        @(posedge clk); #1;
        ok = stall ? 1'b0 : ($urandom_range(0, 99) < 60);
        rd = DW'($urandom);
        hb_ready = we[g] & ok;
        hb_valid = ~we[g] & ok;
        hb_rdat = rd;
        wdat[g] = wd[g][n];
        @(negedge clk);
        fin = ok && (n == l - 1);
        if (we[g]) begin
          check("wrq", bus.hb_wrq_o, !fin);
          check("wready", wready, oh(g, ok));
          if (ok) check("wdat", bus.hb_dat_o, wd[g][n]);
        end else begin
          check("rrq", bus.hb_rrq_o, !fin);
          check("rvalid", rvalid, oh(g, ok));
          if (ok) check("rdat", rdat[g], rd);
        end
        check("xfer_done", done, 0);
        if (ok) begin
          n++;
          stalls = 0;
        end else begin
          stalls++;
        end
      end
      if (abort_after >= 0 && n == abort_after) return;
      @(posedge clk); #1;
      hb_ready = 1'b0;
      hb_valid = 1'b0;
      @(negedge clk);
      check("done", done, oh(g, 1));
      check("err", err, oh(g, n < l));
      check("done_rq", {bus.hb_wrq_o, bus.hb_rrq_o}, 0);
    end
    done_cyc = cyc;
    @(posedge clk); #1;
    req[g] = 1'b0;
    last_g = g;
    // DONE, GAP cycles, one IDLE arbitration cycle, then the first request cycle.
    expect_start = done_cyc + GAP + 2;
  endtask

  task automatic serve_pick(input bit stall);
    int g;
    g = pick(req, last_g);
    serve(g, stall, -1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int l;
    req = 2'b00; we = 2'b00; rg = 2'b00;
    for (int i = 0; i < 2; i++) begin
      adr[i] = '0; len[i] = '0; wdat[i] = '0; wmask[i] = '0;
    end
    hb_ready = 1'b1;
    hb_valid = 1'b1;
    hb_rdat = '0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_fwd", {wready, rvalid}, 0);
    check("rst_done", {done, err}, 0);
    check("rst_rq", {bus.hb_wrq_o, bus.hb_rrq_o}, 0);
    check("rst_mask", bus.hb_mask_o, {MW{1'b1}});
    @(posedge clk); #1;
    rstn = 1'b1;
    hb_ready = 1'b0;
    hb_valid = 1'b0;

    // Directed: m0 write of four words
    post(0, 1'b1, 32'h100, 4, 1'b0);
    expect_start = cyc + 1;
    serve(0, 1'b0, -1);
    // m1 read of three words
    post(1, 1'b0, 32'h2000, 3, 1'b1);
    serve(1, 1'b0, -1);
    // Simultaneous requests alternate
    for (int k = 0; k < 2; k++) begin
      post(0, 1'b1, 32'h40 + k, 2, 1'b0);
      post(1, 1'b0, 32'h80 + k, 3, 1'b0);
      serve_pick(1'b0);
      serve_pick(1'b0);
    end
    // Read that never gets data: timeout
    post(0, 1'b0, 32'h55, 2, 1'b0);
    serve(0, 1'b1, -1);
    // Illegal zero length
    post(1, 1'b1, 32'h77, 0, 1'b0);
    serve(1, 1'b0, -1);

    // Reset mid-write after two of six words, with m1 also waiting
    post(0, 1'b1, 32'h300, 6, 1'b0);
    serve(0, 1'b0, 2);
    @(posedge clk); #1;
    rstn = 1'b0;
    hb_ready = 1'b0;
    hb_valid = 1'b0;
    post(1, 1'b0, 32'h400, 2, 1'b1);
    @(negedge clk);
    check("rstcyc_wrq", bus.hb_wrq_o, 1);
    check("rstcyc_done", done, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    wdat[0] = wd[0][0];
    last_g = 1;
    expect_start = cyc + 1;
    @(negedge clk);
    check("postrst_rq", {bus.hb_wrq_o, bus.hb_rrq_o}, 0);
    check("postrst_done", done, 0);
    @(posedge clk); #1;
    serve_pick(1'b0);
    serve_pick(1'b0);

    // Randomized mix of arrivals, directions and lengths
    for (int k = 0; k < 30; k++) begin
      for (int g = 0; g < 2; g++) begin
        if (!req[g] && ($urandom_range(0, 1) == 1)) begin
          l = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
          post(g, 1'($urandom), AW'($urandom), l, 1'($urandom));
        end
      end
      if (req == 2'b00) post(k % 2, 1'($urandom), AW'($urandom), int'($urandom_range(1, 6)), 1'b0);
      serve_pick(1'b0);
    end
    while (req != 2'b00) serve_pick(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
